// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures the period and high time of sig_in in clk cycles.
// The asynchronous input is synchronised and edge-detected. A four-state FSM
// then runs either a single-shot or a continuous measurement. All counters
// saturate at 2^CNT_W-1, and a saturated measurement is reported as a timeout.
module clk_ratio_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q,   state_d;
  logic             cont_q,    cont_d;
  logic [CNT_W-1:0] wait_q,    wait_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] hcnt_q,    hcnt_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic [CNT_W-1:0] high_q,    high_d;
  logic             timeout_q, timeout_d;
  logic             valid_q,   valid_d;
  logic             s_d_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   rise;
  logic [CNT_W-1:0]       hcnt_inc;

  // Synchroniser chain for the asynchronous input.
  // NOTE: these flops carry no reset. They flush themselves within SYNC_STAGES
  // cycles, and the edge detector below is reset so no false rise escapes.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign rise     = s & ~s_d_q;
  assign hcnt_inc = (hcnt_q == MAX) ? MAX : hcnt_q + CNT_W'(s);

  // State and result registers, with synchronous reset taking priority.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cont_q    <= 1'b0;
      wait_q    <= '0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      s_d_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      s_d_q     <= s;
    end
  end

  // Next-state logic covering arming, counting, result capture and saturation.
  // NOTE: every signal gets a default hold value first, so no branch can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cont_d    = cont_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cont_d  = cont;
          wait_d  = '0;
          state_d = ARM;
        end
      end

      ARM: begin
        if (rise) begin
          cnt_d   = ONE;
          hcnt_d  = ONE;
          state_d = MEAS;
        end else begin
          wait_d = wait_q + ONE;
          // wait_cnt reaches its ceiling in this cycle: give up, even in continuous mode.
          if (wait_q == MAX - ONE) begin
            period_d  = MAX;
            high_d    = '0;
            timeout_d = 1'b1;
            valid_d   = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      MEAS: begin
        if (rise) begin
          period_d  = cnt_q;
          high_d    = hcnt_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          // The closing edge opens the next period in continuous mode.
          cnt_d     = ONE;
          hcnt_d    = ONE;
          state_d   = DONE;
        end else if (cnt_q == MAX) begin
          period_d  = MAX;
          high_d    = hcnt_q;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d  = cnt_q + ONE;
          hcnt_d = hcnt_inc;
        end
      end

      DONE: begin
        // Keep counting so continuous mode loses no cycle of the next period.
        cnt_d   = cnt_q + ONE;
        hcnt_d  = hcnt_inc;
        state_d = cont_q ? MEAS : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter (CNT_W=4). The stimulus is a list of
// (high, low) phase lengths. Each expected result comes from that list: a
// measured period is high+low cycles with high_time=high, unless the period
// outlasts 15 cycles, in which case it is a timeout.
module tb_clk_ratio_meter;

  localparam int CNT_W = 4;
  localparam int INF   = 1000;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             timeout;
    logic             idle_next;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sig_in = 1'b0;
  logic             start = 1'b0;
  logic             cont = 1'b0;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             timeout;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  bit   pend_busy = 1'b0;
  logic exp_busy  = 1'b0;

  clk_ratio_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .start     (start),
    .cont      (cont),
    .busy      (busy),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for one measured period opened by a rise.
  function automatic res_t model(input int h, input int l, input bit idle_next);
    res_t r;
    int   len = h + l;
    if (len <= 15) begin
      r.period    = CNT_W'(len);
      r.high      = CNT_W'(h);
      r.timeout   = 1'b0;
      r.idle_next = idle_next;
    end else begin
      r.period    = 4'hF;
      r.high      = CNT_W'((h > 15) ? 15 : h);
      r.timeout   = 1'b1;
      r.idle_next = 1'b1;
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (pend_busy) begin
        check("busy_after_result", busy, exp_busy);
        pend_busy = 1'b0;
      end
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("period", period, e.period);
          check("high_time", high_time, e.high);
          check("timeout", timeout, e.timeout);
          exp_busy  = ~e.idle_next;
          pend_busy = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic low(input int n);
    sig_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_period(input int h, input int l);
    sig_in = 1'b1;
    for (int i = 0; i < h; i++) tick();
    sig_in = 1'b0;
    for (int i = 0; i < l; i++) tick();
  endtask

  task automatic do_start(input logic c);
    start = 1'b1;
    cont  = c;
    tick();
    start = 1'b0;
    cont  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_drained"}, (n < 200) ? 32'd1 : 32'd0, 32'd1);
    exp_q.delete();
    low(3);
  endtask

  task automatic single_shot(input int h, input int l, input string name);
    low(2);
    do_start(1'b0);
    low(2);
    exp_q.push_back(model(h, l, 1'b1));
    drive_period(h, l);
    drive_period(2, 3);
    wait_drain(name);
  endtask

  task automatic cont_run(input int n, input string name);
    int h, l;
    low(2);
    do_start(1'b1);
    low(2);
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(7, 1);
      l = $urandom_range(8, 1);
      exp_q.push_back(model(h, l, 1'b0));
      drive_period(h, l);
    end
    h = $urandom_range(5, 1);
    exp_q.push_back(model(h, INF, 1'b1));
    drive_period(h, 20);
    wait_drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    // Reset while the input toggles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sig_in = ~sig_in;
      tick();
    end
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b0;
    sig_in = 1'b0;
    mon_en = 1'b1;
    low(4);

    // Divide-by-2 single shot.
    single_shot(1, 1, "div2");

    // Continuous divide-by-8, then divide-by-4 with 1-high/3-low duty.
    low(2);
    do_start(1'b1);
    low(2);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(4, 4, 1'b0));
      drive_period(4, 4);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(1, 3, 1'b0));
      drive_period(1, 3);
    end
    exp_q.push_back(model(1, INF, 1'b1));
    drive_period(1, 20);
    wait_drain("div8_div4");

    // Stuck low in ARM, continuous mode requested: timeout still ends the run.
    do_start(1'b1);
    exp_q.push_back('{period: 4'hF, high: 4'h0, timeout: 1'b1, idle_next: 1'b1});
    low(25);
    wait_drain("stuck_low");

    // One rise, then held high.
    do_start(1'b0);
    low(2);
    exp_q.push_back(model(INF, 0, 1'b1));
    sig_in = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    wait_drain("stuck_high");

    // Longest period that still fits in the counter.
    single_shot(7, 8, "len15");

    // A start (with cont=1) pulsed while busy must be ignored.
    low(2);
    do_start(1'b0);
    low(2);
    exp_q.push_back(model(3, 3, 1'b1));
    sig_in = 1'b1;
    tick();
    start = 1'b1;
    cont  = 1'b1;
    tick();
    start = 1'b0;
    cont  = 1'b0;
    tick();
    drive_period(0, 3);
    drive_period(2, 2);
    drive_period(2, 2);
    wait_drain("start_busy");

    // Random single shots and continuous runs.
    for (int k = 0; k < 6; k++)
      single_shot($urandom_range(7, 1), $urandom_range(8, 1), "rand_single");
    for (int k = 0; k < 3; k++)
      cont_run($urandom_range(6, 3), "rand_cont");

    // Reset mid-measurement in continuous mode.
    low(2);
    do_start(1'b1);
    low(2);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(2, 3, 1'b0));
      drive_period(2, 3);
    end
    drive_period(3, 2);
    check("pre_rst_results_seen", exp_q.size(), 0);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_period", period, 0);
    check("mid_rst_high", high_time, 0);
    check("mid_rst_timeout", timeout, 1'b0);
    tick();
    rst = 1'b0;
    pend_busy = 1'b0;
    low(6);

    // Fresh single shot after the reset.
    single_shot(3, 5, "post_rst");

    low(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
